// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 chunk compression core: FSM state type,
// the round constant table and the message/compression sigma functions.
// All helper functions work on 64-bit containers; in SHA-256 mode only the
// low 32 bits carry data and the upper half of a result is zero.
package sha2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_ADD   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // SHA-512 round constants. The upper 32 bits of the first 64 entries are
    // exactly the SHA-256 round constants, so one table serves both modes.
    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd,
        64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019,
        64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe,
        64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
        64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
        64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
        64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210,
        64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
        64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
        64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
        64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
        64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910,
        64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
        64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
        64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
        64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9,
        64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207,
        64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
        64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493,
        64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
        64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Round constant for round idx; SHA-256 takes the upper half of the entry.
    function automatic logic [63:0] k_word(input logic sha512, input logic [6:0] idx);
        logic [63:0] k;
        k = K512[idx];
        if (sha512) return k;
        return {32'h0, k[63:32]};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] big_sigma0(input logic sha512, input logic [63:0] x);
        logic [31:0] y;
        y = x[31:0];
        if (sha512) return ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
        return {32'h0, ror32(y, 2) ^ ror32(y, 13) ^ ror32(y, 22)};
    endfunction

    function automatic logic [63:0] big_sigma1(input logic sha512, input logic [63:0] x);
        logic [31:0] y;
        y = x[31:0];
        if (sha512) return ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
        return {32'h0, ror32(y, 6) ^ ror32(y, 11) ^ ror32(y, 25)};
    endfunction

    function automatic logic [63:0] small_sigma0(input logic sha512, input logic [63:0] x);
        logic [31:0] y;
        y = x[31:0];
        if (sha512) return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
        return {32'h0, ror32(y, 7) ^ ror32(y, 18) ^ (y >> 3)};
    endfunction

    function automatic logic [63:0] small_sigma1(input logic sha512, input logic [63:0] x);
        logic [31:0] y;
        y = x[31:0];
        if (sha512) return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
        return {32'h0, ror32(y, 17) ^ ror32(y, 19) ^ (y >> 10)};
    endfunction

endpackage

// File: rtl/sha2_round.sv
// One SHA-2 compression round plus the next message schedule word.
// Purely combinational; the caller owns all state. Working variables are
// packed a..h with a in the MSBs.
import sha2_pkg::*;

module sha2_round #(
    parameter bit SHA512 = 1'b1,
    localparam int unsigned WORD_W = SHA512 ? 64 : 32
) (
    input  logic [8*WORD_W-1:0] state_in,
    input  logic [WORD_W-1:0]   k,
    input  logic [WORD_W-1:0]   w0,
    input  logic [WORD_W-1:0]   w1,
    input  logic [WORD_W-1:0]   w9,
    input  logic [WORD_W-1:0]   w14,
    output logic [8*WORD_W-1:0] state_out,
    output logic [WORD_W-1:0]   w_new
);

    logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
    logic [WORD_W-1:0] s0, s1, ss0, ss1, ch, maj, t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;

    assign s0  = WORD_W'(big_sigma0(SHA512, 64'(a)));
    assign s1  = WORD_W'(big_sigma1(SHA512, 64'(e)));
    assign ss0 = WORD_W'(small_sigma0(SHA512, 64'(w1)));
    assign ss1 = WORD_W'(small_sigma1(SHA512, 64'(w14)));
    assign ch  = (e & f) ^ (~e & g);
    assign maj = (a & b) ^ (a & c) ^ (b & c);

    // Round update and schedule extension; all sums wrap at WORD_W bits.
    always_comb begin
        t1        = h + s1 + ch + k + w0;
        t2        = s0 + maj;
        state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
        w_new     = ss1 + w9 + ss0 + w0;
    end

endmodule

// File: rtl/sha2_chunk_core.sv
// SHA-2 chunk compression core, one round per clock, SHA-512 or SHA-256
// selected at elaboration. Holds the FSM, round counter, 16-word schedule
// window, working variables, initial hash and the persistent digest.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a chunk, in_ready=1
// ST_ROUND | one compression round per cycle, r = 0..ROUNDS-1
// ST_ADD   | digest <= H_init + working variables
// ST_OUT   | out_valid=1; may accept the next chunk on the handoff cycle
import sha2_pkg::*;

module sha2_chunk_core #(
    parameter bit SHA512 = 1'b1,
    localparam int unsigned WORD_W  = SHA512 ? 64 : 32,
    localparam int unsigned ROUNDS  = SHA512 ? 80 : 64,
    localparam int unsigned CHUNK_W = 16 * WORD_W,
    localparam int unsigned HASH_W  = 8 * WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] in_chunk,
    input  logic [HASH_W-1:0]  in_h,
    input  logic               in_chain,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [HASH_W-1:0]  out_h
);

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    state_t              state;
    logic [6:0]          r;
    logic [CHUNK_W-1:0]  w_win;
    logic [HASH_W-1:0]   work;
    logic [HASH_W-1:0]   h_init;
    logic [HASH_W-1:0]   digest;
    logic [HASH_W-1:0]   h_sel;
    logic [HASH_W-1:0]   digest_next;
    logic [HASH_W-1:0]   round_state;
    logic [WORD_W-1:0]   k_cur;
    logic [WORD_W-1:0]   w_new;
    logic                accept;

    // in_ready follows out_ready in ST_OUT so a new chunk can be taken on the
    // same edge that hands off the digest, with no idle cycle in between.
    assign in_ready = (state == ST_IDLE) || (state == ST_OUT && out_ready);
    assign accept   = in_valid && in_ready;
    assign h_sel    = in_chain ? digest : in_h;
    assign k_cur    = WORD_W'(k_word(SHA512, r));
    assign out_h    = digest;

    sha2_round #(.SHA512(SHA512)) u_round (
        .state_in  (work),
        .k         (k_cur),
        .w0        (w_win[CHUNK_W-1 -: WORD_W]),
        .w1        (w_win[CHUNK_W-WORD_W-1 -: WORD_W]),
        .w9        (w_win[7*WORD_W-1 -: WORD_W]),
        .w14       (w_win[2*WORD_W-1 -: WORD_W]),
        .state_out (round_state),
        .w_new     (w_new)
    );

    // Word-wise feed-forward of the initial hash into the final working state.
    always_comb begin
        digest_next = '0;
        for (int i = 0; i < 8; i++) begin
            digest_next[i*WORD_W +: WORD_W] = h_init[i*WORD_W +: WORD_W] + work[i*WORD_W +: WORD_W];
        end
    end

    // Control FSM with registered out_valid; datapath registers update with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            r         <= '0;
            w_win     <= '0;
            work      <= '0;
            h_init    <= '0;
            digest    <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            w_win     <= in_chunk;
            h_init    <= h_sel;
            work      <= h_sel;
            r         <= '0;
            out_valid <= 1'b0;
            state     <= ST_ROUND;
        end else begin
            case (state)
                ST_ROUND: begin
                    work  <= round_state;
                    w_win <= {w_win[CHUNK_W-WORD_W-1:0], w_new};
                    if (r == LAST_ROUND) begin
                        r     <= '0;
                        state <= ST_ADD;
                    end else begin
                        r <= r + 7'd1;
                    end
                end
                ST_ADD: begin
                    digest    <= digest_next;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_chunk_core.sv
// Bench for sha2_chunk_core: one SHA-512 and one SHA-256 instance, checked
// against known digests and a textbook SHA-2 compression model.
module tb_sha2_chunk_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] KTAB [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    // SHA-512 instance
    logic          b_reset, b_in_valid, b_in_ready, b_in_chain, b_out_valid, b_out_ready;
    logic [1023:0] b_in_chunk;
    logic [511:0]  b_in_h, b_out_h;
    // SHA-256 instance
    logic          s_reset, s_in_valid, s_in_ready, s_in_chain, s_out_valid, s_out_ready;
    logic [511:0]  s_in_chunk;
    logic [255:0]  s_in_h, s_out_h;

    sha2_chunk_core #(.SHA512(1'b1)) dut512 (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_chunk(b_in_chunk), .in_h(b_in_h), .in_chain(b_in_chain),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_h(b_out_h));

    sha2_chunk_core #(.SHA512(1'b0)) dut256 (
        .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_chunk(s_in_chunk), .in_h(s_in_h), .in_chain(s_in_chain),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_h(s_out_h));

    int n_checks = 0;
    int n_errors = 0;

    logic [511:0] b_exp, b_dig_model;
    logic [255:0] s_exp, s_dig_model;
    time          b_acc_t, s_acc_t;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit big);
        logic [31:0] y, z;
        if (big) return (x >> n) | (x << (64 - n));
        y = x[31:0];
        z = (y >> n) | (y << (32 - n));
        return {32'h0, z};
    endfunction

    function automatic logic [63:0] sig3(input logic [63:0] x, input bit big, input int n1, input int n2, input int n3);
        return rotr(x, n1, big) ^ rotr(x, n2, big) ^ rotr(x, n3, big);
    endfunction

    function automatic logic [63:0] sig2s(input logic [63:0] x, input bit big, input int n1, input int n2, input int sh);
        return rotr(x, n1, big) ^ rotr(x, n2, big) ^ (x >> sh);
    endfunction

    // FIPS 180-4 compression of one chunk with the full expanded schedule.
    function automatic logic [511:0] sha_model(input bit big, input logic [1023:0] chunk, input logic [511:0] hin);
        int          nr;
        logic [63:0] mask, k, t1, t2, s0, s1, ch, maj, sum;
        logic [63:0] w [80];
        logic [63:0] v [8];
        logic [63:0] hw [8];
        logic [511:0] res;
        nr   = big ? 80 : 64;
        mask = big ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        res  = '0;
        for (int i = 0; i < 16; i++)
            w[i] = big ? chunk[1023-64*i -: 64] : {32'h0, chunk[511-32*i -: 32]};
        for (int i = 0; i < 8; i++) begin
            hw[i] = big ? hin[511-64*i -: 64] : {32'h0, hin[255-32*i -: 32]};
            v[i]  = hw[i];
        end
        for (int t = 16; t < nr; t++) begin
            s0 = big ? sig2s(w[t-15], 1'b1, 1, 8, 7) : sig2s(w[t-15], 1'b0, 7, 18, 3);
            s1 = big ? sig2s(w[t-2], 1'b1, 19, 61, 6) : sig2s(w[t-2], 1'b0, 17, 19, 10);
            w[t] = (s1 + w[t-7] + s0 + w[t-16]) & mask;
        end
        for (int t = 0; t < nr; t++) begin
            k   = big ? KTAB[t] : {32'h0, KTAB[t][63:32]};
            s1  = big ? sig3(v[4], 1'b1, 14, 18, 41) : sig3(v[4], 1'b0, 6, 11, 25);
            s0  = big ? sig3(v[0], 1'b1, 28, 34, 39) : sig3(v[0], 1'b0, 2, 13, 22);
            ch  = ((v[4] & v[5]) ^ (~v[4] & v[6])) & mask;
            maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = (v[7] + s1 + ch + k + w[t]) & mask;
            t2  = (s0 + maj) & mask;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4];
            v[4] = (v[3] + t1) & mask;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0];
            v[0] = (t1 + t2) & mask;
        end
        for (int i = 0; i < 8; i++) begin
            sum = (hw[i] + v[i]) & mask;
            if (big) res[511-64*i -: 64] = sum;
            else     res[255-32*i -: 32] = sum[31:0];
        end
        return res;
    endfunction

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- SHA-512 instance drivers ----------------
    task automatic b_send(input logic [1023:0] chunk, input logic [511:0] h, input bit chain);
        int guard;
        logic [1023:0] junk;
        b_exp = sha_model(1'b1, chunk, chain ? b_dig_model : h);
        @(negedge clk);
        b_in_chunk = chunk; b_in_h = h; b_in_chain = chain; b_in_valid = 1'b1;
        guard = 0;
        while (!b_in_ready && guard < 200) begin @(negedge clk); guard++; end
        @(posedge clk);
        b_acc_t = $time;
        #1;
        junk = rnd1024();
        b_in_valid = 1'b0; b_in_chunk = junk; b_in_h = junk[511:0]; b_in_chain = junk[0];
    endtask

    task automatic b_wait(input string tag);
        int guard;
        guard = 0;
        while (!b_out_valid && guard < 300) begin @(posedge clk); #1; guard++; end
        check_val({tag, "_lat"}, 512'(($time - b_acc_t) / 10), 512'd81);
        check_val({tag, "_dig"}, b_out_h, b_exp);
        b_dig_model = b_exp;
    endtask

    task automatic b_pop();
        @(negedge clk); b_out_ready = 1'b1;
        @(posedge clk); #1; b_out_ready = 1'b0;
        check_val("b_pop_valid", 512'(b_out_valid), 512'd0);
    endtask

    // ---------------- SHA-256 instance drivers ----------------
    task automatic s_send(input logic [511:0] chunk, input logic [255:0] h, input bit chain);
        int guard;
        logic [1023:0] junk;
        logic [511:0]  e;
        e = sha_model(1'b0, {512'h0, chunk}, {256'h0, chain ? s_dig_model : h});
        s_exp = e[255:0];
        @(negedge clk);
        s_in_chunk = chunk; s_in_h = h; s_in_chain = chain; s_in_valid = 1'b1;
        guard = 0;
        while (!s_in_ready && guard < 200) begin @(negedge clk); guard++; end
        @(posedge clk);
        s_acc_t = $time;
        #1;
        junk = rnd1024();
        s_in_valid = 1'b0; s_in_chunk = junk[511:0]; s_in_h = junk[767:512]; s_in_chain = junk[0];
    endtask

    task automatic s_wait(input string tag);
        int guard;
        guard = 0;
        while (!s_out_valid && guard < 300) begin @(posedge clk); #1; guard++; end
        check_val({tag, "_lat"}, 512'(($time - s_acc_t) / 10), 512'd65);
        check_val({tag, "_dig"}, 512'(s_out_h), 512'(s_exp));
        s_dig_model = s_exp;
    endtask

    task automatic s_pop();
        @(negedge clk); s_out_ready = 1'b1;
        @(posedge clk); #1; s_out_ready = 1'b0;
        check_val("s_pop_valid", 512'(s_out_valid), 512'd0);
    endtask

    logic [1023:0] abc512, rb;
    logic [511:0]  abc256, blk1, blk2, chunk_b, rs;
    logic [511:0]  dig512;
    logic [255:0]  dig_a, h_b;

    initial begin
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_chain = 1'b0; b_out_ready = 1'b0;
        b_in_chunk = '0; b_in_h = '0;
        s_reset = 1'b1; s_in_valid = 1'b0; s_in_chain = 1'b0; s_out_ready = 1'b0;
        s_in_chunk = '0; s_in_h = '0;
        b_dig_model = '0; s_dig_model = '0;

        abc512 = '0; abc512[1023 -: 32] = 32'h61626380; abc512[7:0] = 8'h18;
        abc256 = '0; abc256[511 -: 32] = 32'h61626380; abc256[7:0] = 8'h18;
        blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk2 = '0; blk2[31:0] = 32'h000001c0;

        repeat (3) @(posedge clk);
        #1;
        b_reset = 1'b0; s_reset = 1'b0;
        check_val("b_rst_ready", 512'(b_in_ready), 512'd1);
        check_val("b_rst_valid", 512'(b_out_valid), 512'd0);
        check_val("b_rst_h", b_out_h, 512'd0);
        check_val("s_rst_ready", 512'(s_in_ready), 512'd1);
        check_val("s_rst_valid", 512'(s_out_valid), 512'd0);
        check_val("s_rst_h", 512'(s_out_h), 512'd0);

        // SHA-512: first transaction chains from the zero digest
        rb = rnd1024();
        b_send(rb, rb[511:0], 1'b1);
        b_wait("b_chain0");
        b_pop();

        // SHA-512: "abc"
        b_send(abc512, IV512, 1'b0);
        b_wait("b_abc");
        dig512 = b_out_h;
        check_val("b_abc_hi", 512'(dig512[511:448]), 512'(64'hddaf35a193617aba));
        check_val("b_abc_lo", 512'(dig512[31:0]), 512'(32'ha54ca49f));
        b_pop();

        // SHA-512: random chunks, random chaining
        for (int i = 0; i < 3; i++) begin
            rb = rnd1024();
            b_send(rb, rb[1023:512], 1'($urandom_range(0, 1)));
            b_wait("b_rand");
            b_pop();
        end

        // SHA-256: "abc"
        s_send(abc256, IV256, 1'b0);
        s_wait("s_abc");
        check_val("s_abc_kat", 512'(s_out_h),
                  512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        s_pop();

        // SHA-256: two-chunk message using the chaining path
        s_send(blk1, IV256, 1'b0);
        s_wait("s_blk1");
        s_pop();
        rs = rnd1024();
        s_send(blk2, rs[255:0], 1'b1);
        s_wait("s_blk2");
        check_val("s_blk2_kat", 512'(s_out_h),
                  512'(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1));
        s_pop();

        // SHA-256: random chunks, random chaining
        for (int i = 0; i < 6; i++) begin
            rb = rnd1024();
            s_send(rb[511:0], rb[767:512], 1'($urandom_range(0, 1)));
            s_wait("s_rand");
            s_pop();
        end

        // Backpressure, then same-edge handoff into the next chunk
        rb = rnd1024();
        s_send(rb[511:0], rb[1023:768], 1'b0);
        s_wait("s_bp_a");
        dig_a = s_exp;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("s_bp_valid", 512'(s_out_valid), 512'd1);
            check_val("s_bp_hold", 512'(s_out_h), 512'(dig_a));
            check_val("s_bp_ready", 512'(s_in_ready), 512'd0);
        end
        rb = rnd1024();
        chunk_b = rb[511:0];
        h_b = rb[767:512];
        rs = sha_model(1'b0, {512'h0, chunk_b}, {256'h0, h_b});
        s_exp = rs[255:0];
        @(negedge clk);
        s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_chunk = chunk_b; s_in_h = h_b; s_in_chain = 1'b0;
        #1;
        check_val("s_handoff_ready", 512'(s_in_ready), 512'd1);
        @(posedge clk);
        s_acc_t = $time;
        #1;
        s_out_ready = 1'b0; s_in_valid = 1'b0;
        check_val("s_handoff_valid", 512'(s_out_valid), 512'd0);
        check_val("s_handoff_busy", 512'(s_in_ready), 512'd0);
        s_wait("s_bp_b");
        s_pop();

        // Reset in the middle of the round phase
        s_send(abc256, IV256, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        s_reset = 1'b1;
        @(posedge clk);
        #1;
        s_reset = 1'b0;
        s_dig_model = '0;
        check_val("s_midrst_ready", 512'(s_in_ready), 512'd1);
        check_val("s_midrst_valid", 512'(s_out_valid), 512'd0);
        check_val("s_midrst_h", 512'(s_out_h), 512'd0);
        s_send(abc256, IV256, 1'b0);
        s_wait("s_post_rst");
        check_val("s_post_rst_kat", 512'(s_out_h),
                  512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        s_pop();

        // in_valid pulsed while busy must be ignored
        rb = rnd1024();
        s_send(rb[511:0], rb[767:512], 1'b0);
        repeat (20) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rs = rnd1024();
            s_in_valid = 1'b1; s_in_chunk = rs; s_in_chain = 1'b0;
            #1;
            check_val("s_busy_ready", 512'(s_in_ready), 512'd0);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        s_wait("s_busy");
        s_pop();
        repeat (5) @(posedge clk);
        #1;
        check_val("s_busy_noextra", 512'(s_out_valid), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
